async_req_tx: RTL and testbench

ASYNC_REQ_TX -- requirements
Module: async_req_tx

---
 rtl/async_req_tx.sv | 148 ++++++++++++++
 tb/tb_async_req_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_req_tx.sv
// async_req_tx: four-phase request/acknowledge transmitter.
// Payload is captured on the accepting edge. It is then held on data_out for the
// whole handshake, while req_out walks through the four-phase protocol against an
// asynchronous ack. The ack is synchronized before use. Each wait phase is
// bounded by a saturating counter, and a stuck receiver lands the FSM in ERR.
module async_req_tx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    REQ     = 3'd2,
    RELEASE = 3'd3,
    ERR     = 3'd4
  } state_t;

  // Compare in 17 bits so TIMEOUT = 65535 never overflows the increment.
  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   terr_q, terr_d;

  logic                   ack_s;
  logic [16:0]            cnt_inc;
  logic                   cnt_hit;
  logic [15:0]            cnt_sat;

  // Synchronizer shift: ack_in enters at bit 0, and only the last stage is used.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Wait-counter helpers. cnt_hit means this cycle's increment reaches TIMEOUT.
  // cnt_sat is the increment, pinned at all-ones so the counter cannot wrap.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + 17'd1;
    cnt_hit = (cnt_inc >= TIMEOUT_L);
    cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_inc[15:0];
  end

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A send that arrives while the old ack is still high is dropped.
        if (send && !ack_s) begin
          data_d  = data_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // One cycle of data setup ahead of the request edge.
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: begin
        // The exit condition is checked first, so it wins over a same-cycle timeout.
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_hit) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_hit) begin
          terr_d  = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      ERR: begin
        // Wait indefinitely for the receiver to let go of ack.
        req_d = 1'b0;
        if (!ack_s) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, synchronizer and output registers. Reset clears everything without a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      req_q      <= req_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  assign req_out     = req_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != IDLE) || ack_s;

endmodule

// File: tb/tb_async_req_tx.sv
// Directed bench for async_req_tx.
// u_dut uses the default TIMEOUT and is driven either by hand or by a behavioural
// receiver. u_tdut uses TIMEOUT = 8 and covers the timeout and ERR behaviour.
module tb_async_req_tx;

  logic        Clk, Reset_n;
  logic        send, ack_in, req_out, busy, done, timeout_err;
  logic [15:0] data_in, data_out;
  logic        t_send, t_ack, t_req, t_busy, t_done, t_terr;
  logic [15:0] t_data, t_dout;

  logic        rx_en, rx_ack, man_ack;
  int          rx_dly, rx_cnt;

  int n_cmp = 0, n_bad = 0;
  int dn = 0, te = 0, tdn = 0, tte = 0, both = 0;

  assign ack_in = rx_en ? rx_ack : man_ack;

  async_req_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(1023)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .send(send), .data_in(data_in), .ack_in(ack_in),
    .req_out(req_out), .data_out(data_out), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  async_req_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(8)) u_tdut (
    .Clk(Clk), .Reset_n(Reset_n), .send(t_send), .data_in(t_data), .ack_in(t_ack),
    .req_out(t_req), .data_out(t_dout), .busy(t_busy), .done(t_done),
    .timeout_err(t_terr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse counters, sampled on the rising edge so the negedge-driven stimulus reads settled counts.
  always @(posedge Clk) begin
    if (done)                dn   <= dn + 1;
    if (timeout_err)         te   <= te + 1;
    if (t_done)              tdn  <= tdn + 1;
    if (t_terr)              tte  <= tte + 1;
    if ((done && timeout_err) || (t_done && t_terr)) both <= both + 1;
  end

  // Behavioural receiver: follows req_out after rx_dly cycles, toggling at a random phase.
  initial begin
    rx_ack = 1'b0;
    rx_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!rx_en) begin
        rx_ack = 1'b0;
        rx_cnt = 0;
      end else if (req_out != rx_ack) begin
        if (rx_cnt >= rx_dly) begin
          #($urandom_range(1, 8));
          rx_ack = ~rx_ack;
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge Clk);
      k++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // One transfer on u_dut, with the receiver model answering.
  task automatic xfer(input logic [15:0] d, input string tag);
    int d0, k, bad;
    wait_idle(tag);
    @(negedge Clk);
    d0      = dn;
    send    = 1'b1;
    data_in = d;
    @(negedge Clk);
    send    = 1'b0;
    data_in = ~d;
    chk({tag, "_cap"}, data_out, d);
    k   = 0;
    bad = 0;
    while (!done && k < 200) begin
      @(negedge Clk);
      if (data_out != d) bad++;
      k++;
    end
    @(negedge Clk);
    chk({tag, "_stable"}, bad, 0);
    chk({tag, "_done"}, dn - d0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, terr_at, low_at, d0, te0, k, bad;
    logic found;
    logic [15:0] d;
    Reset_n = 1'b0;
    send = 1'b0; data_in = '0; man_ack = 1'b0; rx_en = 1'b0; rx_dly = 0;
    t_send = 1'b0; t_data = '0; t_ack = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge Clk);
    chk("rst_req", req_out, 1'b0);
    chk("rst_dout", data_out, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    Reset_n = 1'b1;

    // ---- basic transfer, receiver acks 3 cycles after req ----
    @(negedge Clk);
    send = 1'b1; data_in = 16'hA5C3;
    @(negedge Clk);
    send = 1'b0; data_in = 16'h0;
    chk("t1_dout_accept", data_out, 16'hA5C3);
    chk("t1_req_setup", req_out, 1'b0);
    chk("t1_busy", busy, 1'b1);
    @(negedge Clk);
    chk("t1_req_rise", req_out, 1'b1);
    repeat (3) @(negedge Clk);
    man_ack = 1'b1;
    repeat (2) @(negedge Clk);
    chk("t1_req_hold", req_out, 1'b1);
    @(negedge Clk);
    chk("t1_req_fall", req_out, 1'b0);
    chk("t1_dout_mid", data_out, 16'hA5C3);
    man_ack = 1'b0;
    repeat (2) @(negedge Clk);
    chk("t1_done_early", done, 1'b0);
    chk("t1_busy_rel", busy, 1'b1);
    @(negedge Clk);
    chk("t1_done", done, 1'b1);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_dout_end", data_out, 16'hA5C3);
    @(negedge Clk);
    chk("t1_done_once", done, 1'b0);

    // ---- timeout in REQ with ack stuck low (TIMEOUT = 8) ----
    te0 = tte; d0 = tdn;
    t_send = 1'b1; t_data = 16'hBEEF;
    @(negedge Clk);
    t_send = 1'b0;
    chk("t3_dout", t_dout, 16'hBEEF);
    hi = 0; terr_at = 0; low_at = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge Clk);
      if (t_req) hi++;
      if (t_terr && terr_at == 0) terr_at = i;
      if (!t_busy && low_at == 0) low_at = i;
    end
    chk("t3_req_cycles", hi, 8);
    chk("t3_terr_at", terr_at, 10);
    chk("t3_idle_at", low_at, 11);
    chk("t3_terr_cnt", tte - te0, 1);
    chk("t3_no_done", tdn - d0, 0);

    // ---- timeout in RELEASE with ack held high, then ERR recovery ----
    te0 = tte; d0 = tdn;
    t_send = 1'b1; t_data = 16'h1234;
    @(negedge Clk);
    t_send = 1'b0;
    @(negedge Clk);
    chk("t4_req", t_req, 1'b1);
    t_ack = 1'b1;
    repeat (2) @(negedge Clk);
    chk("t4_req_hold", t_req, 1'b1);
    @(negedge Clk);
    chk("t4_req_fall", t_req, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge Clk);
      if (t_terr) found = 1'b1;
    end
    chk("t4_terr_seen", found, 1'b1);
    t_send = 1'b1; t_data = 16'hFFFF;
    repeat (4) @(negedge Clk);
    t_send = 1'b0;
    chk("t4_err_busy", t_busy, 1'b1);
    chk("t4_err_req", t_req, 1'b0);
    chk("t4_err_dout", t_dout, 16'h1234);
    t_ack = 1'b0;
    repeat (2) @(negedge Clk);
    chk("t4_err_wait", t_busy, 1'b1);
    @(negedge Clk);
    chk("t4_idle", t_busy, 1'b0);
    @(negedge Clk);
    chk("t4_dout_kept", t_dout, 16'h1234);
    chk("t4_req_low", t_req, 1'b0);
    chk("t4_terr_cnt", tte - te0, 1);
    chk("t4_no_done", tdn - d0, 0);

    // ---- send held high for 20 cycles: one transfer only ----
    rx_en = 1'b1; rx_dly = 10;
    wait_idle("t2");
    @(negedge Clk);
    d0 = dn;
    send = 1'b1; data_in = 16'h1111;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (data_out != 16'h1111) bad++;
      data_in = 16'(i * 16'h0101 + 7);
    end
    send = 1'b0;
    wait_idle("t2_end");
    repeat (3) @(negedge Clk);
    chk("t2_stable", bad, 0);
    chk("t2_xfers", dn - d0, 1);
    chk("t2_dout_final", data_out, 16'h1111);

    // ---- asynchronous reset while in REQ ----
    rx_en = 1'b0; man_ack = 1'b0;
    @(negedge Clk);
    d0 = dn; te0 = te;
    send = 1'b1; data_in = 16'hDEAD;
    @(negedge Clk);
    send = 1'b0;
    @(negedge Clk);
    chk("t5_req", req_out, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t5_req_async", req_out, 1'b0);
    chk("t5_dout_async", data_out, 16'h0);
    chk("t5_busy_async", busy, 1'b0);
    chk("t5_done_async", done, 1'b0);
    chk("t5_terr_async", timeout_err, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("t5_no_pulse", (dn - d0) + (te - te0), 0);
    rx_en = 1'b1; rx_dly = 2;
    xfer(16'h0001, "t5");

    // ---- 200 transfers against a random-phase receiver ----
    k = 0;
    for (int i = 0; i < 200; i++) begin
      rx_dly = $urandom_range(0, 3);
      d = 16'($urandom);
      xfer(d, "t6");
      k++;
    end
    chk("t6_count", k, 200);
    chk("no_done_and_terr", both, 0);
    chk("t6_no_terr", te - te0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
